// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_pkg
//  Purpose  : Shared types and helpers for the data-memory responder slice:
//             FSM state encoding, data word width and an index-width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    localparam int WORD_W = 32;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 of a depth; used as the RAM index width
    function automatic int idx_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
//  Module   : mem_word_array
//  Purpose  : DEPTH_WORDS x DATA_W word RAM with one synchronous write port
//             and one synchronous read port. A read and write to the same
//             index on the same edge returns the newly written word.
//             Storage is not reset; only the read-data register is.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_word_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rd_data;

    // Synchronous write port; storage contents survive reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Synchronous read port with write-first forwarding on an index collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            if (i_wr_en && (i_wr_idx == i_rd_idx)) begin
                r_rd_data <= i_wr_data;
            end else begin
                r_rd_data <= r_mem[i_rd_idx];
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : mem_word_array
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Target side of the CPU data-memory port. Accepts a word read
//             or write, inserts WAIT_CYCLES wait states, then completes with
//             a one-cycle mem_ready pulse. Backed by mem_word_array.
//  Options  : MEM_BOUNDS_CHECK_EN - when defined, addresses beyond the RAM
//             are flagged on mem_err, writes to them are dropped and reads
//             return ERR_DATA. When undefined, addresses wrap and the
//             mem_err port does not exist.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int                DEPTH_WORDS = 1024,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [WORD_W-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_ready
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic              mem_err
`endif
);

    localparam int         c_IDX_W     = idx_w(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam bit         c_NO_WAIT   = (WAIT_CYCLES == 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                w_enter_done;

    logic [WORD_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic                r_op_wr;
    logic                r_op_rd;

    logic                w_req;
    logic [WORD_W-1:0]   w_acc_addr;
    logic [WORD_W-1:0]   w_acc_wdata;
    logic                w_acc_wr;
    logic                w_acc_rd;
    logic [c_IDX_W-1:0]  w_acc_idx;
    logic                w_oob;
    logic                w_arr_wr_en;
    logic                w_arr_rd_en;
    logic [WORD_W-1:0]   w_arr_rdata;

    logic                r_ready;
    logic                r_rd_err;
    logic                w_unused_addr;

    assign w_req = mem_read | mem_write;

    // FSM state and wait counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter update and the "entering DONE" strobe
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (c_NO_WAIT) begin
                        w_state_nxt  = DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt  = DONE;
                    w_enter_done = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Capture the request when it is accepted in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_op_wr <= 1'b0;
            r_op_rd <= 1'b0;
        end else if ((r_state == IDLE) && w_req) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_op_wr <= mem_write;
            r_op_rd <= mem_read;
        end
    end

    // With zero wait states the access completes on the accepting edge,
    // so the live inputs stand in for the not-yet-captured registers.
    assign w_acc_addr  = (r_state == IDLE) ? mem_addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? mem_wdata : r_wdata;
    assign w_acc_wr    = (r_state == IDLE) ? mem_write : r_op_wr;
    assign w_acc_rd    = (r_state == IDLE) ? mem_read  : r_op_rd;
    assign w_acc_idx   = w_acc_addr[c_IDX_W+1:2];

`ifdef MEM_BOUNDS_CHECK_EN
    assign w_oob = ((w_acc_addr >> (c_IDX_W + 2)) != '0);
`else
    assign w_oob = 1'b0;
`endif

    // Byte-lane bits and (without bounds checking) upper bits play no role
    assign w_unused_addr = ^{w_acc_addr[1:0], w_acc_addr >> (c_IDX_W + 2)};

    assign w_arr_wr_en = w_enter_done & w_acc_wr & ~w_oob;
    assign w_arr_rd_en = w_enter_done & w_acc_rd & ~w_oob;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W),
        .DATA_W      (WORD_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_arr_wr_en),
        .i_wr_idx  (w_acc_idx),
        .i_wr_data (w_acc_wdata),
        .i_rd_en   (w_arr_rd_en),
        .i_rd_idx  (w_acc_idx),
        .o_rd_data (w_arr_rdata)
    );

    // Completion pulse and the error flag of the last completed read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready  <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_ready <= w_enter_done;
            if (w_enter_done && w_acc_rd) begin
                r_rd_err <= w_oob;
            end
        end
    end

    // An out-of-range read leaves the array register alone and the
    // substitute value is selected here, so it holds like normal read data.
    assign mem_rdata = r_rd_err ? ERR_DATA : w_arr_rdata;
    assign mem_ready = r_ready;

`ifdef MEM_BOUNDS_CHECK_EN
    logic r_err;

    // Range-error flag, aligned with the ready pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_enter_done & w_oob;
        end
    end

    assign mem_err = r_err;
`endif

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Directed, table-driven bench for data_mem_responder
//             (DEPTH_WORDS=1024, WAIT_CYCLES=2). Honours MEM_BOUNDS_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int          c_DEPTH = 1024;
    localparam int          c_WAIT  = 2;
    localparam logic [31:0] c_ERR   = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ready;
`ifdef MEM_BOUNDS_CHECK_EN
    logic        mem_err;
`endif

    int total;
    int bad;

    data_mem_responder #(
        .DEPTH_WORDS (c_DEPTH),
        .WAIT_CYCLES (c_WAIT),
        .ERR_DATA    (c_ERR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef MEM_BOUNDS_CHECK_EN
        ,
        .mem_err   (mem_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one request (called #1 after a rising edge, DUT idle); returns at
    // the cycle where mem_ready is high, with the request already dropped,
    // and reports how many edges passed from the accepting edge onward.
    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
        mem_write = wr;
        mem_read  = rd;
        mem_addr  = a;
        mem_wdata = d;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!mem_ready && lat < 20);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    // Step past the DONE cycle and confirm the pulse lasted one cycle
    task automatic finish_txn(input string name);
        @(posedge clk);
        #1;
        check({name, "_ready_drop"}, {31'd0, mem_ready}, 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int lat;
        int pulses;
        int p1;
        int p2;
        int consec;
        bit prev;

        total = 0;
        bad   = 0;

        vecs[0] = '{wr:1, rd:0, addr:32'h10, wdata:32'h1234_5678, chk:1, exp:32'h0};
        vecs[1] = '{wr:0, rd:1, addr:32'h10, wdata:32'h0,         chk:1, exp:32'h1234_5678};
        vecs[2] = '{wr:1, rd:1, addr:32'h20, wdata:32'hA5A5_A5A5, chk:1, exp:32'hA5A5_A5A5};
        vecs[3] = '{wr:0, rd:1, addr:32'h20, wdata:32'h0,         chk:1, exp:32'hA5A5_A5A5};
        vecs[4] = '{wr:1, rd:0, addr:32'h40, wdata:32'h1111_2222, chk:1, exp:32'hA5A5_A5A5};
        vecs[5] = '{wr:1, rd:0, addr:32'h14, wdata:32'h0BAD_F00D, chk:0, exp:32'h0};
        vecs[6] = '{wr:0, rd:1, addr:32'h12, wdata:32'h0,         chk:1, exp:32'h1234_5678};
        vecs[7] = '{wr:0, rd:1, addr:32'h14, wdata:32'h0,         chk:1, exp:32'h0BAD_F00D};
        vecs[8] = '{wr:1, rd:0, addr:32'h0,  wdata:32'h0000_0777, chk:0, exp:32'h0};

        // Reset and idle behaviour
        rst       = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("reset_ready", {31'd0, mem_ready}, 32'd0);
            check("reset_rdata", mem_rdata, 32'd0);
`ifdef MEM_BOUNDS_CHECK_EN
            check("reset_err", {31'd0, mem_err}, 32'd0);
`endif
        end

        // Table-driven single transactions
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, lat);
            check($sformatf("vec%0d_latency", i), lat, c_WAIT + 1);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp);
            end
`ifdef MEM_BOUNDS_CHECK_EN
            check($sformatf("vec%0d_err", i), {31'd0, mem_err}, 32'd0);
`endif
            finish_txn($sformatf("vec%0d", i));
        end

        // Reset in the middle of a write's wait states
        mem_write = 1'b1;
        mem_addr  = 32'h40;
        mem_wdata = 32'h9999_9999;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        check("rstwait_ready", {31'd0, mem_ready}, 32'd0);
        check("rstwait_rdata", mem_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        consec = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) consec++;
        end
        check("rstwait_no_ready", consec, 0);
        run_txn(1'b0, 1'b1, 32'h40, 32'h0, lat);
        check("rstwait_old_data", mem_rdata, 32'h1111_2222);
        finish_txn("rstwait");

        // Request held across DONE: two transactions, one-cycle pulses
        mem_read = 1'b1;
        mem_addr = 32'h14;
        pulses = 0;
        p1 = 0;
        p2 = 0;
        consec = 0;
        prev = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            if (mem_ready && prev) consec++;
            prev = mem_ready;
            if (mem_ready) begin
                pulses++;
                if (pulses == 1) begin
                    p1 = c;
                end else if (pulses == 2) begin
                    p2 = c;
                    check("held_rdata", mem_rdata, 32'h0BAD_F00D);
                    mem_read = 1'b0;
                    mem_addr = '0;
                end
            end
        end
        mem_read = 1'b0;
        check("held_pulses", pulses, 2);
        check("held_first_latency", p1, c_WAIT + 1);
        check("held_gap", p2 - p1 - 1, c_WAIT + 1);
        check("held_no_consec", consec, 0);

        // Address beyond the array
        run_txn(1'b1, 1'b0, 32'h1000, 32'hCAFE_0001, lat);
        check("oob_wr_latency", lat, c_WAIT + 1);
`ifdef MEM_BOUNDS_CHECK_EN
        check("oob_wr_err", {31'd0, mem_err}, 32'd1);
`endif
        finish_txn("oob_wr");
        run_txn(1'b0, 1'b1, 32'h0, 32'h0, lat);
`ifdef MEM_BOUNDS_CHECK_EN
        check("oob_rd0_rdata", mem_rdata, 32'h0000_0777);
        check("oob_rd0_err", {31'd0, mem_err}, 32'd0);
`else
        check("wrap_rd0_rdata", mem_rdata, 32'hCAFE_0001);
`endif
        finish_txn("oob_rd0");
`ifdef MEM_BOUNDS_CHECK_EN
        run_txn(1'b0, 1'b1, 32'h1000, 32'h0, lat);
        check("oob_rd_latency", lat, c_WAIT + 1);
        check("oob_rd_rdata", mem_rdata, c_ERR);
        check("oob_rd_err", {31'd0, mem_err}, 32'd1);
        finish_txn("oob_rd");
        check("oob_rd_hold", mem_rdata, c_ERR);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_data_mem_responder
`default_nettype wire
